// File: rtl/cpu_cs_useq_ctl.sv
// Control-store microsequencer: issues one microaddress per MACLK pulse and
// executes NEXT/JUMP/CJMP/CALL/RET/STOP commands with a small return stack.
module cpu_cs_useq_ctl #(
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        START,
  input  logic [12:0] START_ADDR_12_0,
  input  logic        CMD_VALID,
  input  logic [2:0]  CMD_2_0,
  input  logic        COND,
  input  logic [12:0] TARGET_12_0,
  output logic [12:0] CSA_12_0,
  output logic        MACLK,
  output logic        PD1,
  output logic        BUSY,
  output logic        ERR,
  output logic [1:0]  ERR_CODE_1_0,
  output logic [2:0]  DEPTH_2_0
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StError} state_e;

  localparam logic [2:0] CmdNext = 3'b000;
  localparam logic [2:0] CmdJump = 3'b001;
  localparam logic [2:0] CmdCjmp = 3'b010;
  localparam logic [2:0] CmdCall = 3'b011;
  localparam logic [2:0] CmdRet  = 3'b100;
  localparam logic [2:0] CmdStop = 3'b101;

  localparam logic [1:0] ErrNone      = 2'b00;
  localparam logic [1:0] ErrOverflow  = 2'b01;
  localparam logic [1:0] ErrUnderflow = 2'b10;
  localparam logic [1:0] ErrReserved  = 2'b11;

  localparam logic [2:0] FullDepth = 3'(STACK_DEPTH);

  state_e      state_q, state_d;
  logic [12:0] csa_q, csa_d;
  logic [12:0] csa_inc;
  logic [12:0] stack_top;
  logic        maclk_q, pd1_q;
  logic [1:0]  err_code_q, err_code_d;
  logic [2:0]  depth_q, depth_d;
  logic        push, clear_stack;
  logic [12:0] stack_q [STACK_DEPTH];

  // 13-bit add wraps 1FFF to 0000 naturally.
  assign csa_inc = csa_q + 13'd1;

  // Entry depth_q-1 is the top of stack.
  always_comb begin
    stack_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (depth_q == 3'(i + 1)) stack_top = stack_q[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    csa_d       = csa_q;
    err_code_d  = err_code_q;
    depth_d     = depth_q;
    push        = 1'b0;
    clear_stack = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          csa_d   = START_ADDR_12_0;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (CMD_VALID) begin
          case (CMD_2_0)
            CmdNext: begin
              csa_d   = csa_inc;
              state_d = StIssue;
            end
            CmdJump: begin
              csa_d   = TARGET_12_0;
              state_d = StIssue;
            end
            CmdCjmp: begin
              csa_d   = COND ? TARGET_12_0 : csa_inc;
              state_d = StIssue;
            end
            CmdCall: begin
              if (depth_q == FullDepth) begin
                err_code_d = ErrOverflow;
                state_d    = StError;
              end else begin
                push    = 1'b1;
                depth_d = depth_q + 3'd1;
                csa_d   = TARGET_12_0;
                state_d = StIssue;
              end
            end
            CmdRet: begin
              if (depth_q == 3'd0) begin
                err_code_d = ErrUnderflow;
                state_d    = StError;
              end else begin
                depth_d = depth_q - 3'd1;
                csa_d   = stack_top;
                state_d = StIssue;
              end
            end
            CmdStop: state_d = StIdle;
            default: begin
              err_code_d = ErrReserved;
              state_d    = StError;
            end
          endcase
        end
      end
      StError: begin
        if (START) begin
          clear_stack = 1'b1;
          depth_d     = '0;
          err_code_d  = ErrNone;
          csa_d       = START_ADDR_12_0;
          state_d     = StIssue;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state_q    <= StIdle;
      csa_q      <= '0;
      maclk_q    <= 1'b0;
      pd1_q      <= 1'b1;
      err_code_q <= ErrNone;
      depth_q    <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      csa_q      <= csa_d;
      // Strobes come from the next state so they toggle only on the clock edge.
      maclk_q    <= (state_d == StIssue);
      pd1_q      <= !((state_d == StIssue) || (state_d == StWait));
      err_code_q <= err_code_d;
      depth_q    <= depth_d;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (clear_stack) begin
          stack_q[i] <= '0;
        end else if (push && (depth_q == 3'(i))) begin
          stack_q[i] <= csa_inc;
        end
      end
    end
  end

  assign CSA_12_0     = csa_q;
  assign MACLK        = maclk_q;
  assign PD1          = pd1_q;
  assign BUSY         = (state_q == StIssue) || (state_q == StWait);
  assign ERR          = (state_q == StError);
  assign ERR_CODE_1_0 = err_code_q;
  assign DEPTH_2_0    = depth_q;

endmodule

// File: tb/tb_cpu_cs_useq_ctl.sv
// Directed and random checks of cpu_cs_useq_ctl against a queue-based
// behavioural model of the sequencer.
module tb_cpu_cs_useq_ctl;

  localparam int unsigned SD = 4;

  logic        CLK = 1'b0;
  logic        RESET_n = 1'b0;
  logic        START = 1'b0;
  logic [12:0] START_ADDR_12_0 = '0;
  logic        CMD_VALID = 1'b0;
  logic [2:0]  CMD_2_0 = '0;
  logic        COND = 1'b0;
  logic [12:0] TARGET_12_0 = '0;
  logic [12:0] CSA_12_0;
  logic        MACLK, PD1, BUSY, ERR;
  logic [1:0]  ERR_CODE_1_0;
  logic [2:0]  DEPTH_2_0;

  cpu_cs_useq_ctl #(.STACK_DEPTH(SD)) dut (
    .CLK            (CLK),
    .RESET_n        (RESET_n),
    .START          (START),
    .START_ADDR_12_0(START_ADDR_12_0),
    .CMD_VALID      (CMD_VALID),
    .CMD_2_0        (CMD_2_0),
    .COND           (COND),
    .TARGET_12_0    (TARGET_12_0),
    .CSA_12_0       (CSA_12_0),
    .MACLK          (MACLK),
    .PD1            (PD1),
    .BUSY           (BUSY),
    .ERR            (ERR),
    .ERR_CODE_1_0   (ERR_CODE_1_0),
    .DEPTH_2_0      (DEPTH_2_0)
  );

  always #5 CLK = ~CLK;

  int n_test = 0;
  int n_fail = 0;

  // Model: mode is one of "idle", "issue", "wait", "error".
  string m_mode = "idle";
  int    m_csa = 0;
  int    m_err = 0;
  int    m_stk[$];
  bit    m_maclk = 1'b0;
  bit    m_pd1 = 1'b1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_test++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (!RESET_n) begin
      m_mode = "idle";
      m_csa  = 0;
      m_err  = 0;
      m_stk.delete();
    end else if (m_mode == "idle") begin
      if (START) begin
        m_csa  = int'(START_ADDR_12_0);
        m_mode = "issue";
      end
    end else if (m_mode == "issue") begin
      m_mode = "wait";
    end else if (m_mode == "wait") begin
      if (CMD_VALID) begin
        case (int'(CMD_2_0))
          0: begin m_csa = (m_csa + 1) % 8192; m_mode = "issue"; end
          1: begin m_csa = int'(TARGET_12_0); m_mode = "issue"; end
          2: begin
            m_csa  = COND ? int'(TARGET_12_0) : (m_csa + 1) % 8192;
            m_mode = "issue";
          end
          3: begin
            if (m_stk.size() == SD) begin
              m_err = 1; m_mode = "error";
            end else begin
              m_stk.push_back((m_csa + 1) % 8192);
              m_csa = int'(TARGET_12_0); m_mode = "issue";
            end
          end
          4: begin
            if (m_stk.size() == 0) begin
              m_err = 2; m_mode = "error";
            end else begin
              m_csa = m_stk.pop_back(); m_mode = "issue";
            end
          end
          5: m_mode = "idle";
          default: begin m_err = 3; m_mode = "error"; end
        endcase
      end
    end else begin
      if (START) begin
        m_stk.delete();
        m_err  = 0;
        m_csa  = int'(START_ADDR_12_0);
        m_mode = "issue";
      end
    end
    m_maclk = (m_mode == "issue");
    m_pd1   = !((m_mode == "issue") || (m_mode == "wait"));
  endtask

  task automatic check_all();
    chk("csa", 16'(CSA_12_0), 16'(m_csa));
    chk("maclk", 16'(MACLK), 16'(m_maclk));
    chk("pd1", 16'(PD1), 16'(m_pd1));
    chk("busy", 16'(BUSY), 16'((m_mode == "issue") || (m_mode == "wait")));
    chk("err", 16'(ERR), 16'(m_mode == "error"));
    chk("err_code", 16'(ERR_CODE_1_0), 16'(m_err));
    chk("depth", 16'(DEPTH_2_0), 16'(m_stk.size()));
  endtask

  task automatic step(input bit rst_n, input bit st, input logic [12:0] sa, input bit cv,
                      input logic [2:0] cmd, input bit cond, input logic [12:0] tgt);
    RESET_n = rst_n; START = st; START_ADDR_12_0 = sa;
    CMD_VALID = cv; CMD_2_0 = cmd; COND = cond; TARGET_12_0 = tgt;
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_step();
    step(1'b1, 1'b0, 13'h0, 1'b0, 3'd0, 1'b0, 13'h0);
  endtask

  // Execute a command in WAIT, check the issued address, then return to WAIT.
  task automatic run_cmd(input logic [2:0] cmd, input bit cond, input logic [12:0] tgt,
                         input logic [12:0] exp_csa, input logic [2:0] exp_depth);
    step(1'b1, 1'b0, 13'h0, 1'b1, cmd, cond, tgt);
    chk("dir_csa", 16'(CSA_12_0), 16'(exp_csa));
    chk("dir_maclk", 16'(MACLK), 16'h1);
    chk("dir_depth", 16'(DEPTH_2_0), 16'(exp_depth));
    idle_step();
    chk("dir_pd1_wait", 16'(PD1), 16'h0);
  endtask

  task automatic start_at(input logic [12:0] sa);
    step(1'b1, 1'b1, sa, 1'b0, 3'd0, 1'b0, 13'h0);
    chk("dir_start_csa", 16'(CSA_12_0), 16'(sa));
    chk("dir_start_maclk", 16'(MACLK), 16'h1);
    idle_step();
  endtask

  initial begin
    // Reset state
    step(1'b0, 1'b1, 13'h1234, 1'b1, 3'd1, 1'b0, 13'h0777);
    chk("rst_csa", 16'(CSA_12_0), 16'h0);
    chk("rst_pd1", 16'(PD1), 16'h1);
    chk("rst_busy", 16'(BUSY), 16'h0);
    idle_step();
    chk("idle_maclk", 16'(MACLK), 16'h0);

    // Sequential issue
    start_at(13'h0100);
    run_cmd(3'd0, 1'b0, 13'h0, 13'h0101, 3'd0);
    run_cmd(3'd0, 1'b0, 13'h0, 13'h0102, 3'd0);
    run_cmd(3'd0, 1'b0, 13'h0, 13'h0103, 3'd0);

    // START in WAIT ignored, STOP returns to IDLE
    step(1'b1, 1'b1, 13'h0555, 1'b0, 3'd0, 1'b0, 13'h0);
    chk("start_in_wait", 16'(CSA_12_0), 16'h0103);
    step(1'b1, 1'b0, 13'h0, 1'b1, 3'd5, 1'b0, 13'h0);
    chk("stop_busy", 16'(BUSY), 16'h0);
    chk("stop_pd1", 16'(PD1), 16'h1);

    // Wrap and conditional jump
    start_at(13'h1FFF);
    run_cmd(3'd0, 1'b0, 13'h0, 13'h0000, 3'd0);
    run_cmd(3'd1, 1'b0, 13'h0005, 13'h0005, 3'd0);
    run_cmd(3'd2, 1'b0, 13'h0ABC, 13'h0006, 3'd0);
    run_cmd(3'd2, 1'b1, 13'h0ABC, 13'h0ABC, 3'd0);

    // Nested call/return
    run_cmd(3'd1, 1'b0, 13'h0010, 13'h0010, 3'd0);
    run_cmd(3'd3, 1'b0, 13'h0200, 13'h0200, 3'd1);
    run_cmd(3'd3, 1'b0, 13'h0300, 13'h0300, 3'd2);
    run_cmd(3'd4, 1'b0, 13'h0, 13'h0201, 3'd1);
    run_cmd(3'd4, 1'b0, 13'h0, 13'h0011, 3'd0);

    // Stack overflow
    for (int i = 0; i < 4; i++) run_cmd(3'd3, 1'b0, 13'(16'h0400 + i), 13'(16'h0400 + i), 3'(i + 1));
    step(1'b1, 1'b0, 13'h0, 1'b1, 3'd3, 1'b0, 13'h0999);
    chk("ovf_err", 16'(ERR), 16'h1);
    chk("ovf_code", 16'(ERR_CODE_1_0), 16'h1);
    chk("ovf_pd1", 16'(PD1), 16'h1);
    chk("ovf_depth", 16'(DEPTH_2_0), 16'h4);
    chk("ovf_csa_held", 16'(CSA_12_0), 16'h0403);
    step(1'b1, 1'b0, 13'h0, 1'b1, 3'd0, 1'b0, 13'h0);
    chk("err_ignores_cmd", 16'(CSA_12_0), 16'h0403);

    // Underflow after recovery
    start_at(13'h0000);
    step(1'b1, 1'b0, 13'h0, 1'b1, 3'd4, 1'b0, 13'h0);
    chk("udf_code", 16'(ERR_CODE_1_0), 16'h2);

    // Reserved command and recovery
    start_at(13'h0020);
    step(1'b1, 1'b0, 13'h0, 1'b1, 3'd6, 1'b0, 13'h0);
    chk("rsv_code", 16'(ERR_CODE_1_0), 16'h3);
    step(1'b1, 1'b1, 13'h0040, 1'b0, 3'd0, 1'b0, 13'h0);
    chk("rcv_csa", 16'(CSA_12_0), 16'h0040);
    chk("rcv_err", 16'(ERR), 16'h0);
    chk("rcv_depth", 16'(DEPTH_2_0), 16'h0);
    idle_step();

    // Reset in WAIT with a populated stack beats START
    run_cmd(3'd3, 1'b0, 13'h0100, 13'h0100, 3'd1);
    run_cmd(3'd3, 1'b0, 13'h0200, 13'h0200, 3'd2);
    step(1'b0, 1'b1, 13'h0777, 1'b1, 3'd0, 1'b0, 13'h0);
    chk("rst_wait_csa", 16'(CSA_12_0), 16'h0);
    chk("rst_wait_depth", 16'(DEPTH_2_0), 16'h0);
    chk("rst_wait_busy", 16'(BUSY), 16'h0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic [2:0]  cmd;
      logic [12:0] sa;
      cmd = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      sa  = ($urandom_range(0, 3) == 0) ? 13'h1FFF : 13'($urandom);
      step($urandom_range(0, 60) != 0, $urandom_range(0, 5) == 0, sa,
           $urandom_range(0, 1) == 1, cmd, $urandom_range(0, 1) == 1, 13'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule
